sipo_deser: RTL
===============

Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserializer, the next-generation SIPO shifter. It collects WIDTH serial bits under a valid/ready handshake and presents each completed word on a registered parallel output with valid/ready backpressure. Bit order (MSB-first or LSB-first) is set by parameter. It sits between a serial receive front-end and a parallel word consumer.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 means the first received bit lands in bit WIDTH-1; 0 means it lands in bit 0.
CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
s_bit  input  1  serial data bit.
s_valid  input  1  s_bit is valid this cycle.
s_ready  output  1  deserializer accepts a bit this cycle.
flush  input  1  abandon the partial word.
m_data  output  WIDTH  completed parallel word.
m_valid  output  1  m_data holds an unconsumed word.
m_ready  input  1  consumer takes m_data this cycle.
bit_cnt  output  CNT_W  bits held in the current partial word (0..WIDTH-1).
busy  output  1  high when bit_cnt != 0.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a rising edge: shreg=0, bit_cnt=0, m_data=0, m_valid=0. rst overrides every other input, so reset mid-word discards the partial word and any held output word.
- Bit accept: when s_valid && s_ready.
- Shift rule, MSB_FIRST=1: shreg_next = {shreg[WIDTH-2:0], s_bit}.
- Shift rule, MSB_FIRST=0: shreg_next = {s_bit, shreg[WIDTH-1:1]}.
- Counting: on each accept, bit_cnt increments by 1. The accept at bit_cnt==WIDTH-1 is the completing bit; it wraps bit_cnt to 0.
- Completion: the completing bit loads m_data with shreg_next and sets m_valid=1 at the same edge. Latency is 1 cycle from last-bit accept to m_valid high. shreg contents after completion are don't-care; the next word overwrites all WIDTH bits.
- Output register state, EMPTY (m_valid=0): becomes FULL on completion.
- Output register state, FULL (m_valid=1):
  - m_ready=1 without completion -> EMPTY.
  - m_ready=1 with completion in the same cycle -> stays FULL with the new word, giving back-to-back words with no bubble.
  - m_ready=0 -> holds m_data and m_valid stable.
- s_ready = !(bit_cnt==WIDTH-1 && m_valid && !m_ready). Non-completing bits are always accepted, even while the output is FULL. Only the completing bit stalls. s_ready is combinational from m_ready, bit_cnt and m_valid, with no path from s_valid.
- flush=1: at the next edge bit_cnt=0 and shreg=0. A simultaneous s_valid bit is dropped and completion is suppressed. m_data and m_valid are unaffected, so a held word survives a flush. s_ready still follows its formula during flush.
- s_valid=0: no state change apart from output drain.
- No overrun is possible: backpressure is lossless.
- Elaboration: $error if WIDTH < 2.

Decomposition:
- No shared package is needed. CNT_W is a local derived parameter. There are no typedefs.
- One sub-module is natural: sipo_out_reg, a WIDTH-parametrised single-entry valid/ready holding register (load, drain, simultaneous load+drain). The top level keeps the shifter, counter, flush and s_ready logic.

Test Plan:
- WIDTH=8, MSB_FIRST=1, m_ready=1, bits 1,0,1,1,0,0,1,0 back-to-back -> m_data=0xB2, with m_valid high for exactly 1 cycle, one cycle after the 8th accept.
- WIDTH=8, MSB_FIRST=0, same bit sequence -> m_data=0x4D; bit_cnt steps 0..7 then wraps to 0.
- m_ready=0, 16 bits back-to-back -> first word 0xB2 held; s_ready drops at bit_cnt=7 of word 2 and stays low. Raise m_ready for 1 cycle -> 0xB2 consumed, the 16th bit is accepted that cycle, and m_data shows word 2 next cycle with m_valid continuously high.
- 3 bits sent, then flush=1 with s_valid=1 -> that bit is dropped and bit_cnt=0; then 8 ones -> m_data=0xFF. A word held before the flush is still presented unchanged.
- Word completes on the same cycle that m_ready=1 drains the previous word -> no m_valid gap, s_ready stays 1, both words delivered in order.
- rst asserted after 5 bits with a held word -> next cycle m_valid=0, m_data=0, bit_cnt=0, busy=0; the following 8 bits form a clean word.

Source files
------------

// File: rtl/sipo_deser_out_reg.sv
// Single-entry valid/ready holding register for completed words.
// Latency: load visible on dat_o/vld_o one cycle after the load edge.
// Backpressure: holds the word while rdy_i=0; load+drain in one cycle replaces the word with no bubble.
module sipo_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] dat_q, dat_d;
  logic             vld_q, vld_d;

  // Next state: a load wins over a drain, so load+drain keeps the entry full with the new word.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (load_i) begin
      dat_d = load_dat_i;
      vld_d = 1'b1;
    end else if (vld_q && rdy_i) begin
      vld_d = 1'b0;
    end
  end

  // Output register with synchronous reset that clears both data and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign dat_o = dat_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: WIDTH bits per word, MSB- or LSB-first.
// Latency: completed word valid one cycle after the last bit is accepted.
// Backpressure: only the completing bit stalls, and only while the held word is not being taken.
module sipo_deser #(
  parameter int      WIDTH     = 8,
  parameter bit      MSB_FIRST = 1'b1,
  localparam int     CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy
);

  if (WIDTH < 2) begin : g_width_chk
    $error("sipo_deser: WIDTH must be at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             last_bit;
  logic             complete;

  assign last_bit = (cnt_q == LAST_CNT);
  // The completing bit may only enter when the output slot is free or being drained this cycle.
  assign s_ready  = !(last_bit && m_valid && !m_ready);
  assign accept   = s_valid && s_ready;
  // A flush drops any bit offered in the same cycle, so it also cancels a completion.
  assign complete = accept && last_bit && !flush;

  // Shift the incoming bit in from the side matching the configured bit order.
  always_comb begin
    if (MSB_FIRST) begin
      shreg_nxt = {shreg_q[WIDTH-2:0], s_bit};
    end else begin
      shreg_nxt = {s_bit, shreg_q[WIDTH-1:1]};
    end
  end

  // Next state of the partial word: flush clears it, an accepted bit shifts and counts (wrapping on completion).
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (flush) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shreg_d = shreg_nxt;
      cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (complete),
    .load_dat_i(shreg_nxt),
    .rdy_i     (m_ready),
    .dat_o     (m_data),
    .vld_o     (m_valid)
  );

  assign bit_cnt = cnt_q;
  assign busy    = (cnt_q != '0);

endmodule
